keypad_scan: RTL



---
 rtl/keypad_scan.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad reader: drives one active-low column per slot, snapshots the
// active-low rows into a 16-key image per scan, debounces whole scans, reports single keys.
module keypad_scan #(
  parameter int SCAN_DIV = 50_000,
  parameter int DB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       pressed
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DB_SCANS > 0) ? $clog2(DB_SCANS + 1) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_SCANS - 1);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } cls_e;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_q, col_d;
  logic [15:0]   snap_q, snap_d;
  logic          scan_done_q, scan_done_d;
  cls_e          cls_q, cls_d;
  logic [3:0]    cls_code_q, cls_code_d;
  logic          cls_valid_q, cls_valid_d;
  cls_e          cand_q, cand_d;
  logic [3:0]    cand_code_q, cand_code_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  cls_e          acc_q, acc_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic [3:0]    key_q, key_d;
  logic          key_valid_q, key_valid_d;
  logic          pressed_q, pressed_d;
  logic [5:0]    cls_word_s;

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:  key_code = 4'h1;
      4'd1:  key_code = 4'h2;
      4'd2:  key_code = 4'h3;
      4'd3:  key_code = 4'hA;
      4'd4:  key_code = 4'h4;
      4'd5:  key_code = 4'h5;
      4'd6:  key_code = 4'h6;
      4'd7:  key_code = 4'hB;
      4'd8:  key_code = 4'h7;
      4'd9:  key_code = 4'h8;
      4'd10: key_code = 4'h9;
      4'd11: key_code = 4'hC;
      4'd12: key_code = 4'h0;
      4'd13: key_code = 4'hF;
      4'd14: key_code = 4'hE;
      default: key_code = 4'hD;
    endcase
  endfunction

  // Snapshot bit index is row*4 + column; returns {class, code}.
  function automatic logic [5:0] classify(input logic [15:0] snap);
    logic [4:0] n;
    logic [3:0] idx;
    n   = 5'd0;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (snap[i]) begin
        n   = n + 5'd1;
        idx = 4'(i);
      end
    end
    if (n == 5'd0) begin
      classify = {CLS_NONE, 4'd0};
    end else if (n == 5'd1) begin
      classify = {CLS_SINGLE, key_code(idx)};
    end else begin
      classify = {CLS_MULTI, 4'd0};
    end
  endfunction

  assign cls_word_s = classify(snap_q);

  always_comb begin
    slot_d      = (slot_q == SLOT_LAST) ? {SW{1'b0}} : slot_q + SW'(1);
    col_idx_d   = col_idx_q;
    col_d       = col_q;
    snap_d      = snap_q;
    scan_done_d = 1'b0;
    if (slot_q == SLOT_LAST) begin
      for (int r = 0; r < 4; r++) begin
        snap_d[{2'(r), col_idx_q}] = ~row_s2_q[r];
      end
      col_idx_d   = col_idx_q + 2'd1;
      col_d       = {col_q[2:0], col_q[3]};
      scan_done_d = (col_idx_q == 2'd3);
    end else begin
      scan_done_d = 1'b0;
    end

    cls_valid_d = scan_done_q;
    if (scan_done_q) begin
      cls_d      = cls_e'(cls_word_s[5:4]);
      cls_code_d = cls_word_s[3:0];
    end else begin
      cls_d      = cls_q;
      cls_code_d = cls_code_q;
    end

    cand_d      = cand_q;
    cand_code_d = cand_code_q;
    db_cnt_d    = db_cnt_q;
    acc_d       = acc_q;
    acc_code_d  = acc_code_q;
    key_d       = key_q;
    pressed_d   = pressed_q;
    key_valid_d = 1'b0;
    if (cls_valid_q) begin
      if ((cls_q == cand_q) && (cls_code_q == cand_code_q)) begin
        db_cnt_d = (db_cnt_q == DB_LAST) ? db_cnt_q : db_cnt_q + DW'(1);
      end else begin
        cand_d      = cls_q;
        cand_code_d = cls_code_q;
        db_cnt_d    = {DW{1'b0}};
      end
      // MULTI is never accepted, so roll-over leaves the previous key in place.
      if ((db_cnt_d == DB_LAST) && (cand_d != CLS_MULTI) &&
          ((cand_d != acc_q) || (cand_code_d != acc_code_q))) begin
        acc_d      = cand_d;
        acc_code_d = cand_code_d;
        if (cand_d == CLS_SINGLE) begin
          key_d       = cand_code_d;
          pressed_d   = 1'b1;
          key_valid_d = 1'b1;
        end else begin
          pressed_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q    <= 4'b1111;
      row_s2_q    <= 4'b1111;
      slot_q      <= {SW{1'b0}};
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      snap_q      <= 16'd0;
      scan_done_q <= 1'b0;
      cls_q       <= CLS_NONE;
      cls_code_q  <= 4'd0;
      cls_valid_q <= 1'b0;
      cand_q      <= CLS_NONE;
      cand_code_q <= 4'd0;
      db_cnt_q    <= {DW{1'b0}};
      acc_q       <= CLS_NONE;
      acc_code_q  <= 4'd0;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      pressed_q   <= 1'b0;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      slot_q      <= slot_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      scan_done_q <= scan_done_d;
      cls_q       <= cls_d;
      cls_code_q  <= cls_code_d;
      cls_valid_q <= cls_valid_d;
      cand_q      <= cand_d;
      cand_code_q <= cand_code_d;
      db_cnt_q    <= db_cnt_d;
      acc_q       <= acc_d;
      acc_code_q  <= acc_code_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      pressed_q   <= pressed_d;
    end
  end

  assign col       = col_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign pressed   = pressed_q;

endmodule
